// File: rtl/apsr_carry_unit_pkg.sv
// Shared ALU definitions: carry-in selects, NZCV flag indices, chain FSM encodings.
package alu_defs;

    localparam logic [1:0] SC_0     = 2'd0;
    localparam logic [1:0] SC_1     = 2'd1;
    localparam logic [1:0] SC_APSR  = 2'd2;
    localparam logic [1:0] SC_CHAIN = 2'd3;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

endpackage

// File: rtl/apsr_carry_unit_chain.sv
// Carry-chain FSM: sequences multi-word ADC/SBC steps, carrying C and Z between words.
module carry_chain_fsm
    import alu_defs::*;
#(
    parameter int CHAIN_MAX = 4,
    parameter int CNT_W     = $clog2(CHAIN_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             chain_start,
    input  logic [CNT_W-1:0] chain_len,
    input  logic             step_valid,
    input  logic             res_zero,
    input  logic             alu_cout,
    input  logic             apsr_c,
    output logic             chain_c,
    output logic             busy,
    output logic             done,
    output logic             idle,
    output logic             last_step,
    output logic             z_word
);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             z_acc;
    logic [CNT_W-1:0] len_sat;

    // Oversized requests are clamped rather than rejected.
    assign len_sat = (chain_len > CNT_W'(CHAIN_MAX)) ? CNT_W'(CHAIN_MAX) : chain_len;

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign idle      = (state == ST_IDLE);
    assign last_step = busy & step_valid & (cnt == CNT_W'(1));
    assign z_word    = z_acc & res_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            chain_c <= 1'b0;
            z_acc   <= 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (chain_start && chain_len != '0) begin
                        state   <= ST_RUN;
                        cnt     <= len_sat;
                        chain_c <= apsr_c;
                        z_acc   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (step_valid) begin
                        chain_c <= alu_cout;
                        z_acc   <= z_word;
                        cnt     <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/apsr_carry_unit.sv
// APSR NZCV register and ALU carry-in select, with optional multi-word carry chain.
// Optional feature macro: CARRY_CHAIN_EN (chain FSM present when defined).
module apsr_carry_unit
    import alu_defs::*;
#(
    parameter int DATA_W    = 32,
    parameter int CHAIN_MAX = 4,
    parameter int CNT_W     = $clog2(CHAIN_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cin_sel,
    input  logic              chain_start,
    input  logic [CNT_W-1:0]  chain_len,
    input  logic              step_valid,
    input  logic              upd_flags,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_vout,
    input  logic              msr_we,
    input  logic [3:0]        msr_nzcv,
    output logic              alu_cin,
    output logic [3:0]        apsr_nzcv,
    output logic              chain_busy,
    output logic              chain_done
);

    logic  res_zero;
    logic  chain_c;
    logic  fsm_idle;
    logic  last_step;
    logic  z_word;
    nzcv_t single_f;
    nzcv_t chain_f;

    assign res_zero = (alu_result == '0);

`ifdef CARRY_CHAIN_EN
    carry_chain_fsm #(
        .CHAIN_MAX (CHAIN_MAX),
        .CNT_W     (CNT_W)
    ) u_chain (
        .clk         (clk),
        .rst         (rst),
        .chain_start (chain_start),
        .chain_len   (chain_len),
        .step_valid  (step_valid),
        .res_zero    (res_zero),
        .alu_cout    (alu_cout),
        .apsr_c      (apsr_nzcv[F_C]),
        .chain_c     (chain_c),
        .busy        (chain_busy),
        .done        (chain_done),
        .idle        (fsm_idle),
        .last_step   (last_step),
        .z_word      (z_word)
    );
`else
    logic unused_chain;

    assign unused_chain = ^{chain_start, chain_len};
    assign chain_c      = apsr_nzcv[F_C];
    assign chain_busy   = 1'b0;
    assign chain_done   = 1'b0;
    assign fsm_idle     = 1'b1;
    assign last_step    = 1'b0;
    assign z_word       = 1'b0;
`endif

    always_comb begin
        alu_cin = 1'b0;
        unique case (cin_sel)
            SC_0:     alu_cin = 1'b0;
            SC_1:     alu_cin = 1'b1;
            SC_APSR:  alu_cin = apsr_nzcv[F_C];
            SC_CHAIN: alu_cin = chain_busy ? chain_c : apsr_nzcv[F_C];
            default:  alu_cin = 1'b0;
        endcase
    end

    assign single_f = '{n: alu_result[DATA_W-1], z: res_zero, c: alu_cout, v: alu_vout};
    assign chain_f  = '{n: alu_result[DATA_W-1], z: z_word, c: alu_cout, v: alu_vout};

    // MSR has priority over any same-cycle flag-setting step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            apsr_nzcv <= 4'b0000;
        end else if (msr_we) begin
            apsr_nzcv <= msr_nzcv;
        end else if (last_step && upd_flags) begin
            apsr_nzcv <= chain_f;
        end else if (fsm_idle && step_valid && upd_flags) begin
            apsr_nzcv <= single_f;
        end
    end

endmodule

// File: tb/tb_apsr_carry_unit.sv
// Scoreboard bench for apsr_carry_unit; chain tests run when CARRY_CHAIN_EN is defined.
module tb_apsr_carry_unit;

    localparam int DATA_W    = 32;
    localparam int CHAIN_MAX = 4;
    localparam int CNT_W     = $clog2(CHAIN_MAX + 1);

    logic              clk;
    logic              rst;
    logic [1:0]        cin_sel;
    logic              chain_start;
    logic [CNT_W-1:0]  chain_len;
    logic              step_valid;
    logic              upd_flags;
    logic [DATA_W-1:0] alu_result;
    logic              alu_cout;
    logic              alu_vout;
    logic              msr_we;
    logic [3:0]        msr_nzcv;
    logic              alu_cin;
    logic [3:0]        apsr_nzcv;
    logic              chain_busy;
    logic              chain_done;

    apsr_carry_unit #(
        .DATA_W    (DATA_W),
        .CHAIN_MAX (CHAIN_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cin_sel     (cin_sel),
        .chain_start (chain_start),
        .chain_len   (chain_len),
        .step_valid  (step_valid),
        .upd_flags   (upd_flags),
        .alu_result  (alu_result),
        .alu_cout    (alu_cout),
        .alu_vout    (alu_vout),
        .msr_we      (msr_we),
        .msr_nzcv    (msr_nzcv),
        .alu_cin     (alu_cin),
        .apsr_nzcv   (apsr_nzcv),
        .chain_busy  (chain_busy),
        .chain_done  (chain_done)
    );

    typedef struct {
        string      name;
        logic [3:0] apsr;
        logic       busy;
        logic       done;
        logic       cin;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (apsr_nzcv !== e.apsr || chain_busy !== e.busy ||
                chain_done !== e.done || alu_cin !== e.cin) begin
                n_fail++;
                $display("FAIL %s: got apsr=%b busy=%b done=%b cin=%b, want apsr=%b busy=%b done=%b cin=%b",
                         e.name, apsr_nzcv, chain_busy, chain_done, alu_cin,
                         e.apsr, e.busy, e.done, e.cin);
            end
        end
    end

    task automatic chk(input string n, input logic [3:0] a,
                       input logic b, input logic d, input logic c);
        exp_t e;
        e.name = n;
        e.apsr = a;
        e.busy = b;
        e.done = d;
        e.cin  = c;
        q.push_back(e);
        @(posedge clk);
        #1;
        step_valid  = 1'b0;
        upd_flags   = 1'b0;
        msr_we      = 1'b0;
        chain_start = 1'b0;
    endtask

    task automatic step(input logic [31:0] r, input logic co,
                        input logic vo, input logic up);
        step_valid = 1'b1;
        upd_flags  = up;
        alu_result = r;
        alu_cout   = co;
        alu_vout   = vo;
    endtask

    task automatic start(input logic [CNT_W-1:0] len);
        chain_start = 1'b1;
        chain_len   = len;
    endtask

    task automatic msr(input logic [3:0] v);
        msr_we   = 1'b1;
        msr_nzcv = v;
    endtask

    initial begin
        rst = 1'b1;
        cin_sel = 2'd0;
        chain_start = 1'b0;
        chain_len = '0;
        step_valid = 1'b0;
        upd_flags = 1'b0;
        alu_result = '0;
        alu_cout = 1'b0;
        alu_vout = 1'b0;
        msr_we = 1'b0;
        msr_nzcv = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("reset", 4'b0000, 0, 0, 0);
        msr(4'b0010);
        chk("msr_pre", 4'b0000, 0, 0, 0);
        cin_sel = 2'd0; chk("sel0", 4'b0010, 0, 0, 0);
        cin_sel = 2'd1; chk("sel1", 4'b0010, 0, 0, 1);
        cin_sel = 2'd2; chk("sel2", 4'b0010, 0, 0, 1);
        cin_sel = 2'd3; chk("sel3_idle", 4'b0010, 0, 0, 1);

        cin_sel = 2'd2;
        step(32'h8000_0000, 1'b0, 1'b1, 1'b1);
        chk("single_pre", 4'b0010, 0, 0, 1);
        chk("single_flags", 4'b1001, 0, 0, 0);

        msr(4'b0100);
        step(32'h0000_0001, 1'b1, 1'b0, 1'b1);
        chk("msr_vs_step_pre", 4'b1001, 0, 0, 0);
        step(32'h0, 1'b1, 1'b1, 1'b0);
        chk("msr_beats_step", 4'b0100, 0, 0, 0);
        chk("no_upd_flags", 4'b0100, 0, 0, 0);

        msr(4'b1111);
        chk("msr_all", 4'b0100, 0, 0, 0);
        cin_sel = 2'd0;
        #1;
        rst = 1'b1;
        chk("async_reset", 4'b0000, 0, 0, 0);
        rst = 1'b0;
        chk("after_reset", 4'b0000, 0, 0, 0);

`ifdef CARRY_CHAIN_EN
        cin_sel = 2'd3;
        start(3'd2);
        chk("add64_start", 4'b0000, 0, 0, 0);
        step(32'h0, 1'b1, 1'b0, 1'b1);
        chk("add64_w0", 4'b0000, 1, 0, 0);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        chk("add64_w1_cin", 4'b0000, 1, 0, 1);
        chk("add64_done", 4'b0100, 0, 1, 0);
        chk("add64_idle", 4'b0100, 0, 0, 0);

        start(3'd2);
        chk("zacc_start", 4'b0100, 0, 0, 0);
        step(32'h1, 1'b0, 1'b0, 1'b1);
        chk("zacc_w0", 4'b0100, 1, 0, 0);
        step(32'h0, 1'b1, 1'b0, 1'b1);
        chk("zacc_w1", 4'b0100, 1, 0, 0);
        chk("zacc_done", 4'b0010, 0, 1, 1);
        chk("zacc_idle", 4'b0010, 0, 0, 1);

        start(3'd3);
        chk("stall_start", 4'b0010, 0, 0, 1);
        start(3'd1);
        chk("stall_gap0_restart", 4'b0010, 1, 0, 1);
        step(32'h5, 1'b0, 1'b0, 1'b1);
        chk("stall_w0", 4'b0010, 1, 0, 1);
        chk("stall_gap1", 4'b0010, 1, 0, 0);
        step(32'h0, 1'b1, 1'b0, 1'b1);
        chk("stall_w1", 4'b0010, 1, 0, 0);
        chk("stall_gap2", 4'b0010, 1, 0, 1);
        chk("stall_gap3", 4'b0010, 1, 0, 1);
        step(32'h8000_0000, 1'b0, 1'b1, 1'b1);
        chk("stall_w2", 4'b0010, 1, 0, 1);
        start(3'd2);
        chk("stall_done", 4'b1001, 0, 1, 0);
        chk("done_start_ignored", 4'b1001, 0, 0, 0);

        start(3'd0);
        chk("len0_start", 4'b1001, 0, 0, 0);
        chk("len0_a", 4'b1001, 0, 0, 0);
        chk("len0_b", 4'b1001, 0, 0, 0);

        start(3'd7);
        chk("len7_start", 4'b1001, 0, 0, 0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        chk("len7_w0", 4'b1001, 1, 0, 0);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        chk("len7_w1", 4'b1001, 1, 0, 1);
        step(32'h0, 1'b1, 1'b0, 1'b0);
        chk("len7_w2", 4'b1001, 1, 0, 1);
        step(32'h0, 1'b1, 1'b0, 1'b1);
        chk("len7_w3", 4'b1001, 1, 0, 1);
        chk("len7_done", 4'b0110, 0, 1, 1);

        start(3'd1);
        chk("msr_chain_start", 4'b0110, 0, 0, 1);
        msr(4'b1001);
        step(32'h0, 1'b0, 1'b0, 1'b1);
        chk("msr_chain_last", 4'b0110, 1, 0, 1);
        chk("msr_chain_done", 4'b1001, 0, 1, 0);
        chk("msr_chain_idle", 4'b1001, 0, 0, 0);

        start(3'd2);
        chk("rst_run_start", 4'b1001, 0, 0, 0);
        step(32'h0, 1'b1, 1'b0, 1'b1);
        chk("rst_run_w0", 4'b1001, 1, 0, 0);
        #1;
        rst = 1'b1;
        chk("rst_run_async", 4'b0000, 0, 0, 0);
        rst = 1'b0;
        chk("rst_run_nodone0", 4'b0000, 0, 0, 0);
        chk("rst_run_nodone1", 4'b0000, 0, 0, 0);
`else
        cin_sel = 2'd3;
        msr(4'b0010);
        chk("nochain_msr", 4'b0000, 0, 0, 0);
        start(3'd2);
        chk("nochain_start", 4'b0010, 0, 0, 1);
        step(32'h0, 1'b0, 1'b0, 1'b0);
        chk("nochain_busy0", 4'b0010, 0, 0, 1);
        msr(4'b0000);
        chk("nochain_busy1", 4'b0010, 0, 0, 1);
        chk("nochain_sel3_c0", 4'b0000, 0, 0, 0);
`endif

        @(posedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
